// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter: FSM state encoding
// and the requester-index width calculation.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  // Width of a requester index; never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_picker.sv
// Round-robin picker: first eligible requester at or after rr_ptr, wrapping
// circularly. Purely combinational; grant is one-hot, grant_idx its index.
module mem_port_arbiter_rr_picker
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ = 3,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] eligible,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  logic [N_REQ-1:0] rotated;
  logic [IDX_W-1:0] offset;
  logic [IDX_W:0]   sum;

  // Rotate so that bit 0 corresponds to the requester at rr_ptr.
  assign rotated = N_REQ'({eligible, eligible} >> rr_ptr);
  assign any     = |eligible;

  // NOTE: every signal driven here gets a default first so no path can leave it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    offset = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (rotated[j]) offset = IDX_W'(j);
    end

    sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (sum >= (IDX_W + 1)'(N_REQ)) sum = sum - (IDX_W + 1)'(N_REQ);
    grant_idx = sum[IDX_W-1:0];

    grant = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = any && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between N_REQ requesters: round-robin grant, one
// transaction in flight, response routed to its owner, flush squashes the pulse.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  localparam int MASK_W = DATA_W / 8,
  localparam int IDX_W  = idx_width(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  input  logic [N_REQ*MASK_W-1:0]   req_wmask,
  input  logic [N_REQ-1:0]          flush_mask,
  output logic [N_REQ-1:0]          resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_we,
  output logic [DATA_W-1:0]         mem_wdata,
  output logic [MASK_W-1:0]         mem_wmask,
  input  logic                      mem_resp_valid,
  input  logic [DATA_W-1:0]         mem_resp_rdata,
  output logic                      busy
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic              squash_q, squash_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [MASK_W-1:0] wmask_q, wmask_d;

  logic [N_REQ-1:0]  eligible;
  logic [N_REQ-1:0]  grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic              complete;
  logic              deliver;

  assign eligible = req_valid & ~flush_mask;

  mem_port_arbiter_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    squash_d   = squash_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    req_ready  = '0;
    resp_valid = '0;
    resp_rdata = '0;
    complete   = 1'b0;
    deliver    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Stray mem_resp_valid here is a protocol error and is ignored.
        if (grant_any && !rst) begin
          req_ready = grant;
          for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
              addr_d  = req_addr[i*ADDR_W +: ADDR_W];
              we_d    = req_we[i];
              wdata_d = req_wdata[i*DATA_W +: DATA_W];
              wmask_d = req_wmask[i*MASK_W +: MASK_W];
            end
          end
          owner_d  = grant_idx;
          squash_d = 1'b0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush_mask[owner_q]) squash_d = 1'b1;
        if (mem_req_ready) begin
          if (mem_resp_valid) complete = 1'b1;
          else                state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush_mask[owner_q]) squash_d = 1'b1;
        if (mem_resp_valid) complete = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // The memory transaction always retires; a flush only hides the pulse.
    if (complete) begin
      state_d  = ST_IDLE;
      rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
      deliver  = !rst && !(squash_q || flush_mask[owner_q]);
      for (int i = 0; i < N_REQ; i++) begin
        resp_valid[i] = deliver && (owner_q == IDX_W'(i));
      end
      if (deliver) resp_rdata = mem_resp_rdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      squash_q <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      squash_q <= squash_d;
      addr_q   <= addr_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_addr      = addr_q;
  assign mem_we        = we_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: reset, single load, round-robin order,
// stalled store, flush squash, same-cycle ready/response.
module tb_mem_port_arbiter;

  localparam int N_REQ  = 3;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MASK_W = DATA_W / 8;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ*MASK_W-1:0] req_wmask;
  logic [N_REQ-1:0]        flush_mask;
  logic [N_REQ-1:0]        resp_valid;
  logic [DATA_W-1:0]       resp_rdata;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_wdata;
  logic [MASK_W-1:0]       mem_wmask;
  logic                    mem_resp_valid;
  logic [DATA_W-1:0]       mem_resp_rdata;
  logic                    busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_we         (req_we),
    .req_wdata      (req_wdata),
    .req_wmask      (req_wmask),
    .flush_mask     (flush_mask),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata),
    .busy           (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] a,
                         input logic we, input logic [31:0] wd, input logic [3:0] wm);
    req_valid[i]            = v;
    req_addr[i*ADDR_W +: ADDR_W]  = a;
    req_we[i]               = we;
    req_wdata[i*DATA_W +: DATA_W] = wd;
    req_wmask[i*MASK_W +: MASK_W] = wm;
  endtask

  task automatic mem_idle();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
  endtask

  // One load through the WAIT path while all requesters stay valid.
  task automatic rr_txn(input int exp_idx, input int n);
    logic [N_REQ-1:0] oh;
    logic [31:0]      rd;
    oh = N_REQ'(1) << exp_idx;
    rd = 32'hA000_0000 + 32'(n);
    settle();
    check($sformatf("rr%0d_ready", n), 64'(req_ready), 64'(oh));
    tick();
    check($sformatf("rr%0d_addr", n), 64'(mem_addr), 64'(32'h1000 + 32'(exp_idx) * 32'h10));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = rd;
    settle();
    check($sformatf("rr%0d_resp", n), 64'(resp_valid), 64'(oh));
    check($sformatf("rr%0d_rdata", n), 64'(resp_rdata), 64'(rd));
    tick();
    mem_idle();
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_we     = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    flush_mask = '0;
    mem_idle();
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_memv", 64'(mem_req_valid), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_resp", 64'(resp_valid), 64'd0);
    rst = 1'b0;
    tick();

    // Single load from requester 1.
    set_req(1, 1'b1, 32'h100, 1'b0, 32'h0, 4'hF);
    settle();
    check("ld_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    settle();
    check("ld_memv", 64'(mem_req_valid), 64'd1);
    check("ld_addr", 64'(mem_addr), 64'h100);
    check("ld_we", 64'(mem_we), 64'd0);
    check("ld_ready_issue", 64'(req_ready), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("ld_wait_memv", 64'(mem_req_valid), 64'd0);
    check("ld_wait_busy", 64'(busy), 64'd1);
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_BEEF;
    settle();
    check("ld_resp", 64'(resp_valid), 64'b010);
    check("ld_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
    tick();
    mem_idle();
    check("ld_done_busy", 64'(busy), 64'd0);
    check("ld_done_resp", 64'(resp_valid), 64'd0);

    // Reset while a load from requester 2 is in WAIT.
    set_req(2, 1'b1, 32'h300, 1'b0, 32'h0, 4'hF);
    tick();
    req_valid = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_idle();
    check("rw_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rw_busy", 64'(busy), 64'd0);
    check("rw_memv", 64'(mem_req_valid), 64'd0);
    check("rw_resp", 64'(resp_valid), 64'd0);

    // Round-robin from rr_ptr=0 with all requesters continuously valid.
    for (int i = 0; i < N_REQ; i++) set_req(i, 1'b1, 32'h1000 + 32'(i) * 32'h10, 1'b0, 32'h0, 4'hF);
    for (int n = 0; n < 6; n++) rr_txn(n % N_REQ, n);
    req_valid = '0;

    // Stalled store from requester 0 while requester 1 also waits.
    set_req(0, 1'b1, 32'h200, 1'b1, 32'h1234_5678, 4'b0011);
    set_req(1, 1'b1, 32'h204, 1'b0, 32'h0, 4'hF);
    settle();
    check("st_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      settle();
      check($sformatf("st_stall%0d_memv", c), 64'(mem_req_valid), 64'd1);
      check($sformatf("st_stall%0d_flds", c),
            {mem_addr[15:0], mem_we, mem_wmask, mem_wdata[31:0], 11'd0},
            {16'h0200, 1'b1, 4'b0011, 32'h1234_5678, 11'd0});
      check($sformatf("st_stall%0d_ready", c), 64'(req_ready), 64'd0);
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b1;
    settle();
    check("st_resp", 64'(resp_valid), 64'b001);
    tick();
    mem_idle();
    settle();
    check("st_single_pulse", 64'(resp_valid), 64'd0);

    // Requester 1 load: ready and response in the same ISSUE cycle.
    check("same_ready", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hCAFE_F00D;
    settle();
    check("same_resp", 64'(resp_valid), 64'b010);
    check("same_rdata", 64'(resp_rdata), 64'hCAFE_F00D);
    tick();
    mem_idle();
    check("same_idle", 64'(busy), 64'd0);

    // Fetch flushed during WAIT: response consumed but not delivered.
    set_req(0, 1'b1, 32'h400, 1'b0, 32'h0, 4'hF);
    tick();
    req_valid = '0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    flush_mask = 3'b001;
    tick();
    flush_mask = '0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h5555_AAAA;
    settle();
    check("fl_resp", 64'(resp_valid), 64'd0);
    check("fl_rdata", 64'(resp_rdata), 64'd0);
    tick();
    mem_idle();
    check("fl_idle", 64'(busy), 64'd0);
    req_valid = 3'b011;
    settle();
    check("fl_next_grant", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b1;
    tick();
    mem_idle();

    // Flush in IDLE blocks the only valid requester.
    req_valid  = 3'b001;
    flush_mask = 3'b001;
    settle();
    check("fl_idle_ready", 64'(req_ready), 64'd0);
    tick();
    check("fl_idle_busy", 64'(busy), 64'd0);
    req_valid  = '0;
    flush_mask = '0;

    // Stray memory response in IDLE is ignored.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'h1111_2222;
    settle();
    check("stray_resp", 64'(resp_valid), 64'd0);
    tick();
    mem_idle();
    check("stray_busy", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
